// File: rtl/mc_phase_sequencer.sv
// Table-driven multicycle phase sequencer: per-class phase count, memory/busy stalls, busy timeout, exception entry.
// Outputs decode registered state combinationally (no added latency); hold, mem_ready and unit_busy freeze the phase.
module mc_phase_sequencer #(
    parameter int                      NUM_CLS   = 16,
    parameter int                      PH_W      = 3,
    parameter logic [NUM_CLS*PH_W-1:0] LEN_TABLE = {16{3'd3}},
    parameter logic [NUM_CLS-1:0]      EXT_MASK  = 16'h0008,
    parameter logic [NUM_CLS-1:0]      MEM_MASK  = 16'h0006,
    parameter int                      MEM_PH    = 3,
    parameter logic [NUM_CLS-1:0]      WAIT_MASK = 16'h0040,
    parameter int                      TMO_W     = 6,
    localparam int                     CLS_W     = $clog2(NUM_CLS),
    localparam int                     NPH       = 2**PH_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CLS_W-1:0] cls_id,
    input  logic             ext_req,
    input  logic             mem_ready,
    input  logic             unit_busy,
    input  logic             exc_req,
    input  logic             hold,
    output logic [NPH-1:0]   phase,
    output logic             fetch_en,
    output logic             unit_start,
    output logic             instr_done,
    output logic             exc_ack,
    output logic             tmo_err,
    output logic             stall
);

    localparam logic [PH_W-1:0] MEM_PH_V = PH_W'(MEM_PH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_EXC
    } state_t;

    state_t           state_q, state_d;
    logic [PH_W-1:0]  ph_q, ph_d;
    logic [CLS_W-1:0] cls_q, cls_d;
    logic             ext_q, ext_d;
    logic             started_q, started_d;
    logic             tmo_err_q, tmo_err_d;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

    logic [CLS_W-1:0] cls_eff;
    logic [PH_W-1:0]  len_raw;
    logic [PH_W-1:0]  len_eff;
    logic [PH_W:0]    last_sum;
    logic [PH_W-1:0]  last_ph;
    logic             is_ext;
    logic             is_mem;
    logic             is_wait;
    logic             ext_now;
    logic             at_last;
    logic             hold_mem;
    logic             hold_busy;
    logic             tmo_fire;
    logic             held;
    logic             done_run;
    logic             start_now;

    // The class is only on cls_id during phase 1, so that phase decodes it live.
    always_comb begin : decode
        cls_eff   = (ph_q == PH_W'(1)) ? cls_id : cls_q;
        len_raw   = LEN_TABLE[int'(cls_eff)*PH_W +: PH_W];
        len_eff   = (len_raw == '0) ? PH_W'(1) : len_raw;
        is_ext    = EXT_MASK[cls_eff];
        is_mem    = MEM_MASK[cls_eff];
        is_wait   = WAIT_MASK[cls_eff];
        ext_now   = ext_q | (is_ext & ext_req & (ph_q == len_eff));
        last_sum  = {1'b0, len_eff} + (PH_W+1)'(ext_now);
        last_ph   = last_sum[PH_W] ? '1 : last_sum[PH_W-1:0];
        at_last   = (ph_q == last_ph);
        hold_mem  = is_mem & (ph_q == MEM_PH_V) & ~mem_ready;
        hold_busy = is_wait & at_last & unit_busy;
        tmo_fire  = hold_busy & (tmo_cnt_q == '1);
        held      = hold | hold_mem | (hold_busy & ~tmo_fire);
        done_run  = at_last & ~held;
        start_now = (ph_q == PH_W'(1)) & is_wait & ~started_q;
    end

    always_comb begin : fsm
        state_d    = state_q;
        ph_d       = ph_q;
        cls_d      = cls_q;
        ext_d      = ext_q;
        started_d  = started_q;
        tmo_cnt_d  = tmo_cnt_q;
        tmo_err_d  = tmo_err_q;
        phase      = '0;
        fetch_en   = 1'b0;
        unit_start = 1'b0;
        instr_done = 1'b0;
        exc_ack    = 1'b0;
        stall      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                state_d = ST_RUN;
                ph_d    = '0;
            end
            ST_RUN: begin
                phase      = NPH'(1) << ph_q;
                fetch_en   = (ph_q == '0);
                unit_start = start_now;
                stall      = held;
                if (ph_q == PH_W'(1)) begin
                    cls_d = cls_id;
                end
                // Timeout counter saturates so a memory hold at the same phase cannot wrap it.
                if (!hold) begin
                    if (hold_busy && !done_run) begin
                        tmo_cnt_d = (tmo_cnt_q == '1) ? tmo_cnt_q : tmo_cnt_q + TMO_W'(1);
                    end else begin
                        tmo_cnt_d = '0;
                    end
                end
                if (done_run) begin
                    instr_done = 1'b1;
                    ph_d       = '0;
                    ext_d      = 1'b0;
                    started_d  = 1'b0;
                    if (hold_busy) begin
                        tmo_err_d = 1'b1;
                    end
                    if (exc_req) begin
                        state_d = ST_EXC;
                    end
                end else begin
                    ext_d     = ext_now;
                    started_d = started_q | start_now;
                    if (!held) begin
                        ph_d = ph_q + PH_W'(1);
                    end
                end
            end
            ST_EXC: begin
                exc_ack = 1'b1;
                stall   = hold;
                if (!hold) begin
                    instr_done = 1'b1;
                    state_d    = ST_RUN;
                    ph_d       = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign tmo_err = tmo_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            ph_q      <= '0;
            cls_q     <= '0;
            ext_q     <= 1'b0;
            started_q <= 1'b0;
            tmo_cnt_q <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ph_q      <= ph_d;
            cls_q     <= cls_d;
            ext_q     <= ext_d;
            started_q <= started_d;
            tmo_cnt_q <= tmo_cnt_d;
            tmo_err_q <= tmo_err_d;
        end
    end

endmodule
